// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential 32/16 unsigned divider:
//   - default operand widths and iteration-counter width
//   - quotient value reported for a divide by zero
//   - FSM state encoding
// -----------------------------------------------------------------------------
package divider_pkg;

    localparam int DIVIDEND_WIDTH_DEFAULT = 32;
    localparam int DIVISOR_WIDTH_DEFAULT  = 16;
    // Counter must count 0..DIVIDEND_WIDTH-1, so 2**CNT_WIDTH > DIVIDEND_WIDTH.
    localparam int CNT_WIDTH_DEFAULT      = 6;

    // All-ones quotient flags a divide by zero (the "infinite" result).
    localparam logic [DIVIDEND_WIDTH_DEFAULT-1:0] DIV_BY_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divState_t;

endpackage

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// divider_step
// One combinational restoring-division step.
// Ports:
//   remIn       in   DIVISOR_WIDTH  current partial remainder (always < divisor)
//   dividendBit in   1              next dividend bit shifted into the remainder
//   divisor     in   DIVISOR_WIDTH  divisor
//   remOut      out  DIVISOR_WIDTH  new partial remainder
//   quotientBit out  1              quotient bit produced by this step
// -----------------------------------------------------------------------------
module divider_step
    import divider_pkg::*;
#(
    parameter int DIVISOR_WIDTH = DIVISOR_WIDTH_DEFAULT
) (
    input  logic [DIVISOR_WIDTH-1:0] remIn,
    input  logic                     dividendBit,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    output logic [DIVISOR_WIDTH-1:0] remOut,
    output logic                     quotientBit
);

    // The shifted remainder R' is DIVISOR_WIDTH+1 bits wide; its MSB is
    // remIn's MSB, so only the low DIVISOR_WIDTH bits are formed here.
    logic [DIVISOR_WIDTH-1:0] shiftedLow;

    assign shiftedLow = {remIn[DIVISOR_WIDTH-2:0], dividendBit};

    // If R' has its top bit set it already exceeds any divisor.
    assign quotientBit = remIn[DIVISOR_WIDTH-1] | (shiftedLow >= divisor);

    // The true difference is < divisor, so the modular low-bit subtraction
    // is exact even when R' carried into the extra top bit.
    assign remOut = quotientBit ? (shiftedLow - divisor) : shiftedLow;

endmodule

// File: rtl/sequential_divider_32by16.sv
// -----------------------------------------------------------------------------
// sequential_divider_32by16
// Iterative restoring unsigned divider, one quotient bit per clock.
// Ports:
//   Clock       in   1   clock, all state on posedge
//   Reset       in   1   asynchronous active-low reset
//   iStart      in   1   start request, honoured in IDLE or DONE
//   iData_A     in   32  dividend, captured on the accepting edge
//   iData_B     in   16  divisor, captured on the accepting edge
//   oBusy       out  1   high for the DIVIDEND_WIDTH iteration cycles
//   oDone       out  1   one-cycle pulse when results are updated
//   oDivByZero  out  1   divide-by-zero flag, valid with oDone, held
//   oQuotient   out  32  quotient, held until the next result
//   oRemainder  out  16  remainder, held until the next result
// Timing: accept on edge 0, oBusy high after edges 1..32, oDone after edge 33.
// A zero divisor skips RUN: oDone after edge 1.
// -----------------------------------------------------------------------------
module sequential_divider_32by16
    import divider_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_DEFAULT,
    parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_DEFAULT,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEFAULT
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      iStart,
    input  logic [DIVIDEND_WIDTH-1:0] iData_A,
    input  logic [DIVISOR_WIDTH-1:0]  iData_B,
    output logic                      oBusy,
    output logic                      oDone,
    output logic                      oDivByZero,
    output logic [DIVIDEND_WIDTH-1:0] oQuotient,
    output logic [DIVISOR_WIDTH-1:0]  oRemainder
);

    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(DIVIDEND_WIDTH - 1);

    divState_t                 stateReg;
    logic [CNT_WIDTH-1:0]      cntReg;
    // Dividend bits shift out of the top while quotient bits shift in at
    // the bottom, so after the last step this register holds the quotient.
    logic [DIVIDEND_WIDTH-1:0] dividendReg;
    logic [DIVISOR_WIDTH-1:0]  divisorReg;
    logic [DIVISOR_WIDTH-1:0]  remReg;
    logic                      zeroReg;
    logic                      busyReg;
    logic                      doneReg;
    logic                      divByZeroReg;
    logic [DIVIDEND_WIDTH-1:0] quotientReg;
    logic [DIVISOR_WIDTH-1:0]  remainderReg;

    logic                      accept;
    logic [DIVISOR_WIDTH-1:0]  stepRem;
    logic                      stepBit;

    assign accept = iStart && ((stateReg == IDLE) || (stateReg == DONE));

    divider_step #(
        .DIVISOR_WIDTH(DIVISOR_WIDTH)
    ) uStep (
        .remIn      (remReg),
        .dividendBit(dividendReg[DIVIDEND_WIDTH-1]),
        .divisor    (divisorReg),
        .remOut     (stepRem),
        .quotientBit(stepBit)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stateReg     <= IDLE;
            cntReg       <= '0;
            dividendReg  <= '0;
            divisorReg   <= '0;
            remReg       <= '0;
            zeroReg      <= 1'b0;
            busyReg      <= 1'b0;
            doneReg      <= 1'b0;
            divByZeroReg <= 1'b0;
            quotientReg  <= '0;
            remainderReg <= '0;
        end else begin
            doneReg <= 1'b0;
            // Registered one cycle behind the state so that oBusy covers
            // exactly the edges on which an iteration is being computed.
            busyReg <= (stateReg == RUN);

            case (stateReg)
                IDLE: ;
                RUN: begin
                    dividendReg <= {dividendReg[DIVIDEND_WIDTH-2:0], stepBit};
                    remReg      <= stepRem;
                    cntReg      <= cntReg + CNT_WIDTH'(1);
                    if (cntReg == LAST_STEP) begin
                        stateReg <= DONE;
                    end
                end
                DONE: begin
                    doneReg      <= 1'b1;
                    divByZeroReg <= zeroReg;
                    quotientReg  <= zeroReg ? {DIVIDEND_WIDTH{1'b1}} : dividendReg;
                    remainderReg <= zeroReg ? '0 : remReg;
                    stateReg     <= IDLE;
                end
                default: stateReg <= IDLE;
            endcase

            // A start overrides the state update above. When it lands in
            // DONE, the finishing result is still published on this edge,
            // including its divide-by-zero flag.
            if (accept) begin
                dividendReg <= iData_A;
                divisorReg  <= iData_B;
                remReg      <= '0;
                cntReg      <= '0;
                zeroReg     <= (iData_B == '0);
                stateReg    <= (iData_B == '0) ? DONE : RUN;
                if (stateReg == IDLE) begin
                    divByZeroReg <= 1'b0;
                end
            end
        end
    end

    assign oBusy      = busyReg;
    assign oDone      = doneReg;
    assign oDivByZero = divByZeroReg;
    assign oQuotient  = quotientReg;
    assign oRemainder = remainderReg;

endmodule
